// File: rtl/mem_stage_lsu_if.sv
`timescale 1ns/1ps
// Data-memory bus between the MEM-stage LSU and data memory.
// req is held until gnt; rvalid returns read data at least one cycle later.
interface mem_stage_lsu_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/mem_stage_lsu.sv
`timescale 1ns/1ps
// MEM-stage load/store unit.
// req/gnt/rvalid bus, byte lanes, load extension.
module mem_stage_lsu #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        ex_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        lsu_stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misalign,
  output logic        bus_err,
  mem_stage_lsu_if.master dmem
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state;
  state_t      state_nx;
  logic [1:0]  size;
  logic        sign;
  logic        legal;
  logic        aligned;
  logic        access;
  logic        start;
  logic        bad;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        sign_q;
  logic        kill;
  logic [31:0] lane;
  logic [31:0] ext;
  logic        tmo;

  always_comb begin
    size  = 2'd2;
    sign  = 1'b0;
    legal = 1'b1;
    unique case (funct3)
      3'b000:  begin size = 2'd0; sign = 1'b1; end
      3'b001:  begin size = 2'd1; sign = 1'b1; end
      3'b010:  size = 2'd2;
      3'b100:  size = 2'd0;
      3'b101:  size = 2'd1;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    aligned = 1'b1;
    unique case (1'b1)
      size == 2'd1: aligned = ~addr[0];
      size == 2'd2: aligned = (addr[1:0] == 2'b00);
      default:      aligned = 1'b1;
    endcase
  end

  always_comb begin
    be    = 4'b1111;
    wdata = store_data;
    unique case (size)
      2'd0: begin
        be    = 4'b0001 << addr[1:0];
        wdata = {4{store_data[7:0]}};
      end
      2'd1: begin
        be    = 4'b0011 << addr[1:0];
        wdata = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign access = ex_valid & (mem_read | mem_write)
                & ~flush & (state == IDLE);
  assign start  = access & aligned & legal;
  assign bad    = access & ~(aligned & legal);

  assign lane = dmem.dmem_rdata >> {off_q, 3'b000};

  always_comb begin
    ext = lane;
    unique case (size_q)
      2'd0:    ext = {{24{sign_q & lane[7]}}, lane[7:0]};
      2'd1:    ext = {{16{sign_q & lane[15]}}, lane[15:0]};
      default: ;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic          idle_cyc;

  assign idle_cyc = (state == REQ  & ~dmem.dmem_gnt)
                  | (state == WAIT & ~dmem.dmem_rvalid);
  assign tmo = idle_cyc
             & (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      bus_err <= 1'b0;
    end else begin
      bus_err <= tmo;
      if (state_nx != state || state == IDLE)
        cnt <= '0;
      else if (idle_cyc)
        cnt <= cnt + 1'b1;
    end
  end
`else
  assign tmo     = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = REQ;
      REQ: begin
        if (dmem.dmem_gnt)
          state_nx = we_q ? IDLE : WAIT;
        else if (flush | tmo)
          state_nx = IDLE;
      end
      WAIT: if (dmem.dmem_rvalid | tmo) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    lsu_stall     = start | (state != IDLE);
    dmem.dmem_req = (state == REQ);
  end

  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign dmem.dmem_be    = be_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      off_q      <= '0;
      size_q     <= '0;
      sign_q     <= 1'b0;
      kill       <= 1'b0;
      load_data  <= '0;
      load_valid <= 1'b0;
      misalign   <= 1'b0;
    end else begin
      load_valid <= 1'b0;
      misalign   <= bad;
      if (start) begin
        we_q    <= mem_write & ~mem_read;
        addr_q  <= {addr[31:2], 2'b00};
        wdata_q <= wdata;
        be_q    <= be;
        off_q   <= addr[1:0];
        size_q  <= size;
        sign_q  <= sign;
        kill    <= 1'b0;
      end
      if (state != IDLE && flush) kill <= 1'b1;
      if (state == WAIT && dmem.dmem_rvalid
          && !kill && !flush) begin
        load_data  <= ext;
        load_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage_lsu.sv
`timescale 1ns/1ps
// Randomized self-checking bench for mem_stage_lsu against a byte-level model.
module tb_mem_stage_lsu;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        ex_valid;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        lsu_stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        misalign;
    logic        bus_err;

    mem_stage_lsu_if bus();

    mem_stage_lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .ex_valid   (ex_valid),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .lsu_stall  (lsu_stall),
        .load_data  (load_data),
        .load_valid (load_valid),
        .misalign   (misalign),
        .bus_err    (bus_err),
        .dmem       (bus.master)
    );

    always #5 clk = ~clk;

`ifdef LSU_TIMEOUT_EN
    localparam int GD_LONG = 3;
`else
    localparam int GD_LONG = 5;
`endif

    int tests = 0;
    int fails = 0;
    logic [31:0] last_ld = '0;

    int          o_req, o_stall, o_lv, o_lv_k, o_mis, o_err;
    logic        o_stable, o_we;
    logic [31:0] o_ld, o_addr, o_wdata;
    logic [3:0]  o_be;

    function automatic int nbytes(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3,
                                             input logic [1:0] off,
                                             input logic [31:0] w);
        int n;
        longint v;
        n = nbytes(f3);
        if (n == 4) return w;
        v = 0;
        for (int i = n - 1; i >= 0; i--)
            v = v * 256 + longint'(w[8 * (int'(off) + i) +: 8]);
        if (f3[2] == 1'b0 && v >= (64'sd1 << (8 * n - 1)))
            v = v - (64'sd1 << (8 * n));
        return v[31:0];
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3,
                                          input logic [1:0] off);
        logic [3:0] b;
        for (int i = 0; i < 4; i++)
            b[i] = (i >= int'(off)) && (i < int'(off) + nbytes(f3));
        return b;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3,
                                              input logic [31:0] sd);
        logic [31:0] d;
        for (int i = 0; i < 4; i++)
            d[8 * i +: 8] = sd[8 * (i % nbytes(f3)) +: 8];
        return d;
    endfunction

    task automatic run_access(input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] sd, input int gd,
                              input int rvd, input logic [31:0] rdata,
                              input int fl_at);
        int last;
        o_req = 0; o_stall = 0; o_lv = 0; o_lv_k = -1;
        o_mis = 0; o_err = 0; o_stable = 1'b1;
        o_ld = '0; o_addr = '0; o_wdata = '0; o_be = '0; o_we = 1'b0;
        last = 4 + gd + ((rvd < 0) ? 0 : rvd);
        for (int k = 0; k <= last; k++) begin
            @(posedge clk); #1;
            ex_valid   = (k == 0);
            mem_read   = rd;
            mem_write  = wr;
            funct3     = f3;
            addr       = a;
            store_data = sd;
            flush      = (k == fl_at);
            bus.dmem_gnt    = (k == 1 + gd);
            bus.dmem_rvalid = (rvd >= 0) && (k == 1 + gd + rvd);
            bus.dmem_rdata  = bus.dmem_rvalid ? rdata : $urandom;
            @(negedge clk);
            if (lsu_stall) o_stall++;
            if (bus.dmem_req) begin
                if (o_req == 0) begin
                    o_addr = bus.dmem_addr; o_wdata = bus.dmem_wdata;
                    o_be = bus.dmem_be; o_we = bus.dmem_we;
                end else if ({o_addr, o_wdata, o_be, o_we} !==
                    {bus.dmem_addr, bus.dmem_wdata, bus.dmem_be, bus.dmem_we})
                    o_stable = 1'b0;
                o_req++;
            end
            if (load_valid) begin o_lv++; o_ld = load_data; o_lv_k = k; end
            if (misalign) o_mis++;
            if (bus_err) o_err++;
        end
        @(posedge clk); #1;
        ex_valid = 0; flush = 0; bus.dmem_gnt = 0; bus.dmem_rvalid = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests++;
        if ({lsu_stall, load_valid, misalign, bus_err, bus.dmem_req,
             bus.dmem_we} !== 6'b0) begin
            fails++;
            $display("FAIL reset_ctl: got %b want 000000", {lsu_stall,
                     load_valid, misalign, bus_err, bus.dmem_req, bus.dmem_we});
        end
        tests++;
        if ({load_data, bus.dmem_addr, bus.dmem_wdata, bus.dmem_be} !== '0) begin
            fails++;
            $display("FAIL reset_data: ld %h addr %h wd %h be %b want 0",
                     load_data, bus.dmem_addr, bus.dmem_wdata, bus.dmem_be);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_load_word();
        run_access(1, 0, 3'b010, 32'h100, 32'h0, 0, 1, 32'hDEADBEEF, -1);
        tests++;
        if (o_lv !== 1 || o_lv_k !== 3) begin
            fails++;
            $display("FAIL lw_latency: got %0d pulses at k=%0d want 1 at 3",
                     o_lv, o_lv_k);
        end
        tests++;
        if (o_ld !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL lw_data: got %h want deadbeef", o_ld);
        end
        tests++;
        if (o_stall !== 3 || o_req !== 1) begin
            fails++;
            $display("FAIL lw_stall: stall %0d req %0d want 3 1", o_stall, o_req);
        end
        last_ld = 32'hDEADBEEF;
    endtask

    task automatic test_load_byte();
        run_access(1, 0, 3'b000, 32'h103, 32'h0, 0, 1, 32'h80FFFFFF, -1);
        tests++;
        if (o_lv !== 1 || o_ld !== 32'hFFFFFF80) begin
            fails++;
            $display("FAIL lb: got %h (%0d) want ffffff80", o_ld, o_lv);
        end
        run_access(1, 0, 3'b100, 32'h103, 32'h0, 0, 1, 32'h80FFFFFF, -1);
        tests++;
        if (o_lv !== 1 || o_ld !== 32'h00000080) begin
            fails++;
            $display("FAIL lbu: got %h (%0d) want 00000080", o_ld, o_lv);
        end
        last_ld = 32'h00000080;
    endtask

    task automatic test_store();
        run_access(0, 1, 3'b001, 32'h102, 32'h1234ABCD, 0, -1, 32'h0, -1);
        tests++;
        if (o_be !== 4'b1100 || o_wdata !== 32'hABCDABCD) begin
            fails++;
            $display("FAIL sh_lanes: be %b wd %h want 1100 abcdabcd",
                     o_be, o_wdata);
        end
        tests++;
        if (o_addr !== 32'h100 || o_we !== 1'b1) begin
            fails++;
            $display("FAIL sh_addr: addr %h we %b want 100 1", o_addr, o_we);
        end
        tests++;
        if (o_stall !== 2 || o_lv !== 0) begin
            fails++;
            $display("FAIL sh_stall: stall %0d lv %0d want 2 0", o_stall, o_lv);
        end
    endtask

    task automatic test_misalign();
        run_access(1, 0, 3'b010, 32'h101, 32'h0, 0, 1, 32'h55555555, -1);
        tests++;
        if (o_mis !== 1 || o_req !== 0 || o_stall !== 0) begin
            fails++;
            $display("FAIL lw_misalign: mis %0d req %0d stall %0d want 1 0 0",
                     o_mis, o_req, o_stall);
        end
        tests++;
        if (load_data !== last_ld || o_lv !== 0) begin
            fails++;
            $display("FAIL misalign_hold: ld %h want %h", load_data, last_ld);
        end
    endtask

    task automatic test_gnt_delay();
        run_access(1, 0, 3'b001, 32'h202, 32'h0, GD_LONG, 1, 32'h7F00ABCD, -1);
        tests++;
        if (o_req !== GD_LONG + 1 || o_stable !== 1'b1) begin
            fails++;
            $display("FAIL gnt_delay_req: req %0d stable %b want %0d 1",
                     o_req, o_stable, GD_LONG + 1);
        end
        tests++;
        if (o_lv !== 1 || o_ld !== 32'h00007F00) begin
            fails++;
            $display("FAIL gnt_delay_data: got %h want 00007f00", o_ld);
        end
        last_ld = 32'h00007F00;
    endtask

    task automatic test_flush_wait();
        run_access(1, 0, 3'b010, 32'h300, 32'h0, 0, 2, 32'h13572468, 2);
        tests++;
        if (o_lv !== 0 || load_data !== last_ld) begin
            fails++;
            $display("FAIL flush_wait: lv %0d ld %h want 0 %h",
                     o_lv, load_data, last_ld);
        end
        tests++;
        if (o_stall !== 4 || lsu_stall !== 1'b0) begin
            fails++;
            $display("FAIL flush_stall: stall %0d now %b want 4 0",
                     o_stall, lsu_stall);
        end
    endtask

    task automatic test_back_to_back();
        for (int it = 0; it < 40; it++) begin
            logic        rd, wr, good;
            logic [2:0]  f3;
            logic [31:0] a, sd, rdat, exp;
            int          gd, rvd, n, est;
            logic [2:0]  f3s [8];
            f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101,
                    3'b011, 3'b110, 3'b010};
            rd   = 1'($urandom_range(0, 1));
            wr   = rd ? 1'($urandom_range(0, 1)) : 1'b1;
            f3   = f3s[$urandom_range(0, 7)];
            a    = $urandom;
            sd   = $urandom;
            rdat = $urandom;
            gd   = $urandom_range(0, 3);
            rvd  = $urandom_range(1, 3);
            n    = nbytes(f3);
            good = (n != 0) && (int'(a[1:0]) % n == 0);
            run_access(rd, wr, f3, a, sd, gd, rd ? rvd : -1, rdat, -1);
            if (!good) begin
                tests++;
                if (o_mis !== 1 || o_req !== 0 || o_stall !== 0 ||
                    load_data !== last_ld) begin
                    fails++;
                    $display("FAIL rnd_bad[%0d]: mis %0d req %0d stall %0d ld %h",
                             it, o_mis, o_req, o_stall, load_data);
                end
                continue;
            end
            est = rd ? gd + 2 + rvd : gd + 2;
            tests++;
            if (o_req !== gd + 1 || o_stall !== est || o_mis !== 0) begin
                fails++;
                $display("FAIL rnd_timing[%0d]: req %0d stall %0d want %0d %0d",
                         it, o_req, o_stall, gd + 1, est);
            end
            tests++;
            if (o_addr !== {a[31:2], 2'b00} || o_we !== ~rd) begin
                fails++;
                $display("FAIL rnd_addr[%0d]: addr %h we %b want %h %b",
                         it, o_addr, o_we, {a[31:2], 2'b00}, ~rd);
            end
            if (rd) begin
                exp = ref_load(f3, a[1:0], rdat);
                tests++;
                if (o_lv !== 1 || o_ld !== exp) begin
                    fails++;
                    $display("FAIL rnd_load[%0d]: got %h (%0d) want %h",
                             it, o_ld, o_lv, exp);
                end
                last_ld = exp;
            end else begin
                tests++;
                if (o_be !== ref_be(f3, a[1:0]) ||
                    o_wdata !== ref_wdata(f3, sd) || o_lv !== 0) begin
                    fails++;
                    $display("FAIL rnd_store[%0d]: be %b wd %h want %b %h",
                             it, o_be, o_wdata, ref_be(f3, a[1:0]),
                             ref_wdata(f3, sd));
                end
            end
        end
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout();
        run_access(1, 0, 3'b010, 32'h400, 32'h0, 100, -1, 32'h0, -1);
        tests++;
        if (o_req !== 4 || o_err !== 1 || o_stall !== 5) begin
            fails++;
            $display("FAIL timeout: req %0d err %0d stall %0d want 4 1 5",
                     o_req, o_err, o_stall);
        end
        tests++;
        if (o_lv !== 0 || load_data !== last_ld) begin
            fails++;
            $display("FAIL timeout_hold: ld %h want %h", load_data, last_ld);
        end
    endtask
`endif

    task automatic test_async_reset();
        @(posedge clk); #1;
        ex_valid = 1; mem_read = 1; mem_write = 0;
        funct3 = 3'b010; addr = 32'h500;
        @(posedge clk); #1;
        ex_valid = 0;
        @(negedge clk);
        tests++;
        if (bus.dmem_req !== 1'b1) begin
            fails++;
            $display("FAIL areset_pre: req %b want 1", bus.dmem_req);
        end
        #2 reset_n = 1'b0;
        #1;
        tests++;
        if (bus.dmem_req !== 1'b0 || lsu_stall !== 1'b0 || load_data !== '0) begin
            fails++;
            $display("FAIL areset: req %b stall %b ld %h want 0 0 0",
                     bus.dmem_req, lsu_stall, load_data);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        last_ld = '0;
    endtask

    initial begin
        reset_n = 1'b0;
        flush = 0; ex_valid = 0; mem_read = 0; mem_write = 0;
        funct3 = '0; addr = '0; store_data = '0;
        bus.dmem_gnt = 0; bus.dmem_rvalid = 0; bus.dmem_rdata = '0;
        repeat (2) @(posedge clk);
        test_reset();
        test_load_word();
        test_load_byte();
        test_store();
        test_misalign();
        test_gnt_delay();
        test_flush_wait();
        test_back_to_back();
`ifdef LSU_TIMEOUT_EN
        test_timeout();
`endif
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
